// File: rtl/prefetch_fifo_sc_param_if.sv
// Handshake/status bundle for prefetch_fifo_sc_param.
//   master : producer/consumer side (drives wr_en, wr_data, rd_en)
//   slave  : FIFO side (drives wr_vld, rd_vld, rd_data, level, flags)
// Signals:
//   wr_en/wr_vld/wr_data   write request, write-ready, write word
//   rd_en/rd_vld/rd_data   pop request, head-valid, head word (FWFT)
//   level                  words held, 0..2**DEPTH_WIDTH+1
//   almost_full/empty      threshold flags on level
//   ovf_err/udf_err        sticky refused-write / refused-read flags
interface prefetch_fifo_sc_param_if #(
  parameter int unsigned DATA_WIDTH  = 24,
  parameter int unsigned DEPTH_WIDTH = 10
);
  logic                  wr_en;
  logic                  wr_vld;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_en;
  logic                  rd_vld;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [DEPTH_WIDTH:0]  level;
  logic                  almost_full;
  logic                  almost_empty;
  logic                  ovf_err;
  logic                  udf_err;

  modport master (
    output wr_en, wr_data, rd_en,
    input  wr_vld, rd_vld, rd_data, level, almost_full, almost_empty, ovf_err, udf_err
  );

  modport slave (
    input  wr_en, wr_data, rd_en,
    output wr_vld, rd_vld, rd_data, level, almost_full, almost_empty, ovf_err, udf_err
  );
endinterface

// File: rtl/prefetch_fifo_sc_param.sv
// Single-clock first-word-fall-through FIFO: a 2**DEPTH_WIDTH-entry RAM followed by one
// output register that presents the head word before it is popped. Total capacity is
// 2**DEPTH_WIDTH+1 words.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   clr    synchronous flush (present only when FIFO_SCLR_EN is defined)
//   bus    prefetch_fifo_sc_param_if.slave: write/read handshakes, level, flags
// Optional feature: define FIFO_SCLR_EN to add the clr flush input.
module prefetch_fifo_sc_param #(
  parameter int unsigned DATA_WIDTH  = 24,
  parameter int unsigned DEPTH_WIDTH = 10,
  parameter int unsigned AF_LEVEL    = 2**DEPTH_WIDTH - 16,
  parameter int unsigned AE_LEVEL    = 16
) (
  input logic clk,
  input logic rst_n,
`ifdef FIFO_SCLR_EN
  input logic clr,
`endif
  prefetch_fifo_sc_param_if.slave bus
);

  localparam int unsigned DEPTH = 2**DEPTH_WIDTH;

  typedef logic [DEPTH_WIDTH-1:0] ptr_t;
  typedef logic [DEPTH_WIDTH:0]   cnt_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  ptr_t                  wr_ptr_q, wr_ptr_d;
  ptr_t                  rd_ptr_q, rd_ptr_d;
  cnt_t                  mem_cnt_q, mem_cnt_d;
  logic                  rd_vld_q, rd_vld_d;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  wr_vld_q, wr_vld_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;

  logic                  wr_acc;
  logic                  rd_acc;
  logic                  fetch;
  logic                  mem_we;
  logic                  rd_load;
  cnt_t                  level;

  always_comb begin
    wr_acc    = bus.wr_en & wr_vld_q;
    rd_acc    = bus.rd_en & rd_vld_q;
    // Refill the output register when it is empty or being popped this cycle.
    fetch     = (mem_cnt_q != '0) & (~rd_vld_q | rd_acc);

    mem_we    = wr_acc;
    rd_load   = fetch;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    rd_vld_d  = rd_vld_q;
    mem_cnt_d = mem_cnt_q + cnt_t'(wr_acc) - cnt_t'(fetch);
    ovf_d     = ovf_q | (bus.wr_en & ~wr_vld_q);
    udf_d     = udf_q | (bus.rd_en & ~rd_vld_q);

    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + ptr_t'(1);
    end
    if (fetch) begin
      rd_ptr_d = rd_ptr_q + ptr_t'(1);
      rd_vld_d = 1'b1;
    end else if (rd_acc) begin
      rd_vld_d = 1'b0;
    end

`ifdef FIFO_SCLR_EN
    // Flush wins over any concurrent request; rd_data keeps its stale value.
    if (clr) begin
      mem_we    = 1'b0;
      rd_load   = 1'b0;
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      mem_cnt_d = '0;
      rd_vld_d  = 1'b0;
      ovf_d     = 1'b0;
      udf_d     = 1'b0;
    end
`endif

    // Registered ready: a pop at full frees a slot only from the next cycle on.
    wr_vld_d = (mem_cnt_d < cnt_t'(DEPTH));
  end

  // RAM array carries no reset; its contents are only meaningful under mem_cnt.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_ptr_q] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      mem_cnt_q <= '0;
      rd_vld_q  <= 1'b0;
      rd_data_q <= '0;
      wr_vld_q  <= 1'b0;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      mem_cnt_q <= mem_cnt_d;
      rd_vld_q  <= rd_vld_d;
      wr_vld_q  <= wr_vld_d;
      ovf_q     <= ovf_d;
      udf_q     <= udf_d;
      if (rd_load) begin
        rd_data_q <= mem[rd_ptr_q];
      end
    end
  end

  assign level            = mem_cnt_q + cnt_t'(rd_vld_q);
  assign bus.level        = level;
  assign bus.wr_vld       = wr_vld_q;
  assign bus.rd_vld       = rd_vld_q;
  assign bus.rd_data      = rd_data_q;
  assign bus.almost_full  = (32'(level) >= AF_LEVEL);
  assign bus.almost_empty = (32'(level) <= AE_LEVEL);
  assign bus.ovf_err      = ovf_q;
  assign bus.udf_err      = udf_q;

endmodule
